// File: rtl/gpo_pkg.sv
// rtl/gpo_pkg.sv - shared widths, word layout and dispatch state encoding
package gpo_pkg;

  localparam int TS_WIDTH         = 64;
  localparam int PAYLOAD_WIDTH    = 64;
  localparam int DATA_WIDTH       = TS_WIDTH + PAYLOAD_WIDTH;
  localparam int LATE_COUNT_WIDTH = 16;

  // Queue word: timestamp in the upper half, payload in the lower half.
  typedef struct packed {
    logic [TS_WIDTH-1:0]      ts;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } gpo_word_t;

  // IDLE: queue empty or timeline stopped. ARMED: head valid and running.
  typedef enum logic {
    DISP_IDLE  = 1'b0,
    DISP_ARMED = 1'b1
  } disp_state_t;

endpackage

// File: rtl/gpo_sync_fifo.sv
// rtl/gpo_sync_fifo.sv - synchronous first-word-fall-through FIFO with registered head
module gpo_sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full queue is
  // still accepted when paired with a pop.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the count excludes them.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;

endmodule

// File: rtl/gpo_timed_dispatcher.sv
// rtl/gpo_timed_dispatcher.sv - timestamp-ordered event queue feeding the GPO core
module gpo_timed_dispatcher #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 64,
  parameter int DATA_WIDTH = 128
) (
  input  logic                                  CLK100MHZ,
  input  logic                                  reset,
  input  logic                                  write_en,
  input  logic [DATA_WIDTH-1:0]                 write_data,
  output logic                                  full,
  output logic                                  empty,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  input  logic                                  counter_start,
  input  logic                                  counter_stop,
  input  logic                                  counter_clear,
  output logic [TS_WIDTH-1:0]                   counter_value,
  output logic                                  counter_matched,
  output logic [DATA_WIDTH-1:0]                 gpo_in,
  output logic                                  timestamp_error,
  output logic [gpo_pkg::LATE_COUNT_WIDTH-1:0]  late_count,
  output logic                                  overflow_error,
  input  logic                                  error_clear
);

  import gpo_pkg::*;

  localparam logic [LATE_COUNT_WIDTH-1:0] LATE_MAX = '1;

  logic [DATA_WIDTH-1:0]       head_data;
  logic                        head_valid;
  logic [TS_WIDTH-1:0]         head_ts;
  logic                        q_full;

  logic [TS_WIDTH-1:0]         counter_q, counter_d;
  logic                        run_q, run_d;
  logic                        matched_q;
  logic                        ts_err_q;
  logic [DATA_WIDTH-1:0]       gpo_q;
  logic [LATE_COUNT_WIDTH-1:0] late_cnt_q, late_cnt_d;
  logic                        ovf_q, ovf_d;

  disp_state_t                 disp_state;
  logic                        hit;
  logic                        late;
  logic                        pop;
  logic                        drop;

  gpo_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK100MHZ),
    .rst_i   (reset),
    .push_i  (write_en),
    .data_i  (write_data),
    .pop_i   (pop),
    .head_o  (head_data),
    .valid_o (head_valid),
    .full_o  (q_full),
    .count_o (fifo_count)
  );

  assign head_ts = head_data[DATA_WIDTH-1 -: TS_WIDTH];

  // Dispatch decision: compare the head timestamp against the live timeline.
  always_comb begin
    disp_state = DISP_IDLE;
    hit        = 1'b0;
    late       = 1'b0;
    if (run_q && head_valid) begin
      disp_state = DISP_ARMED;
    end
    case (disp_state)
      DISP_ARMED: begin
        hit  = (head_ts == counter_q);
        late = (head_ts <  counter_q);
      end
      default: begin
        hit  = 1'b0;
        late = 1'b0;
      end
    endcase
    pop  = hit || late;
    drop = write_en && q_full && !pop;
  end

  // Next-state for the timeline, run flag and error bookkeeping.
  always_comb begin
    counter_d = counter_q;
    if (counter_clear) begin
      counter_d = '0;
    end else if (run_q) begin
      counter_d = counter_q + TS_WIDTH'(1);
    end

    run_d = run_q;
    if (counter_stop) begin
      run_d = 1'b0;
    end else if (counter_start) begin
      run_d = 1'b1;
    end

    // A new late event outranks a same-cycle clear.
    late_cnt_d = late_cnt_q;
    if (late) begin
      late_cnt_d = error_clear ? LATE_COUNT_WIDTH'(1)
                 : (late_cnt_q == LATE_MAX) ? late_cnt_q
                 : late_cnt_q + LATE_COUNT_WIDTH'(1);
    end else if (error_clear) begin
      late_cnt_d = '0;
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (error_clear) begin
      ovf_d = 1'b0;
    end
  end

  // Registered timeline, strobes, dispatched word and error state.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      counter_q  <= '0;
      run_q      <= 1'b0;
      matched_q  <= 1'b0;
      ts_err_q   <= 1'b0;
      gpo_q      <= '0;
      late_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      run_q      <= run_d;
      matched_q  <= hit;
      ts_err_q   <= late;
      if (hit) begin
        gpo_q <= head_data;
      end
      late_cnt_q <= late_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign full            = q_full;
  assign empty           = !head_valid;
  assign counter_value   = counter_q;
  assign counter_matched = matched_q;
  assign gpo_in          = gpo_q;
  assign timestamp_error = ts_err_q;
  assign late_count      = late_cnt_q;
  assign overflow_error  = ovf_q;

endmodule

// File: doc/gpo_timed_dispatcher.md
Name: gpo_timed_dispatcher

Overview:
- Timestamp-ordered event queue directly upstream of the GPO core.
- Software/AXI side pushes 128-bit words: {timestamp[63:0], payload[63:0]}.
- A free-running 64-bit timeline counter runs against the queue head; on an exact match the block emits the word plus a one-cycle counter_matched strobe, which the GPO core consumes as gpo_in/counter_matched.
- Late entries are discarded and flagged.

Parameters:
- FIFO_DEPTH, 16, queue entries; power of 2, >= 2.
- TS_WIDTH, 64, timestamp and counter width; occupies word bits [127:64].
- DATA_WIDTH, 128, full word width.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- write_en  in  1  push write_data this cycle.
- write_data  in  128  {timestamp[127:64], payload[63:0]}.
- full  out  1  queue full.
- empty  out  1  queue empty (no valid head).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held, including the head register.
- counter_start  in  1  set the run flag.
- counter_stop  in  1  clear the run flag.
- counter_clear  in  1  zero the counter.
- counter_value  out  64  current timeline counter.
- counter_matched  out  1  one-cycle dispatch strobe to the GPO core.
- gpo_in  out  128  dispatched word; held between strobes.
- timestamp_error  out  1  one-cycle pulse when a late entry is discarded.
- late_count  out  16  late discards; saturates at 16'hFFFF.
- overflow_error  out  1  sticky: a write was dropped.
- error_clear  in  1  clears overflow_error and late_count.

Behaviour:
- Reset (synchronous, active-high, takes priority at any time, including mid-dispatch):
  - Queue flushed; counter = 0; run flag = 0.
  - counter_matched, timestamp_error, overflow_error = 0; gpo_in = 0; late_count = 0.
  - empty = 1; full = 0; fifo_count = 0.
- Counter:
  - Priority: counter_clear, then counter_stop, then counter_start.
  - counter_clear zeroes the counter without changing the run flag.
  - start and stop in the same cycle: stop wins.
  - When running, the counter increments by 1 per cycle; wraps 2^64-1 -> 0 with no flag.
- Queue:
  - First-word-fall-through. The head is registered and valid the cycle after a write into an empty queue.
  - Write while full is dropped and sets overflow_error, unless a pop occurs in the same cycle; then the write is accepted.
  - Simultaneous push and pop leaves fifo_count unchanged.
- Dispatch FSM, evaluated each cycle while the run flag = 1 and the head is valid (states derived: IDLE = empty or stopped, ARMED = head valid and running):
  - head.ts == counter_value: pop. Next cycle counter_matched = 1 and gpo_in = head word. Latency is exactly 1 cycle from the matching counter value.
  - head.ts < counter_value (unsigned): pop. Next cycle timestamp_error = 1, late_count +1 (saturating); counter_matched stays 0 and gpo_in is unchanged.
  - head.ts > counter_value: hold.
- Throughput:
  - One pop per cycle is sustainable; consecutive timestamps t, t+1, t+2 produce strobes on three consecutive cycles.
  - Two entries with equal timestamps: first dispatched, second counted late.
- Stopped counter: no compare and no pops; the queue holds its contents.
- counter_clear while running: compare uses the cleared value on the following cycle. Entries with timestamps above 0 remain pending.
- error_clear in the same cycle as a new overflow or late event: the new event wins (flag set, or count = 1).
- The GPO core's busy signal is not consumed here. Busy collisions are reported by the GPO core; this block never stalls on busy.

Decomposition:
- Package gpo_pkg:
  - TS_WIDTH, DATA_WIDTH, PAYLOAD_WIDTH constants.
  - typedef gpo_word_t packed struct {ts, payload}.
  - LATE_COUNT_WIDTH = 16.
- Sub-module gpo_sync_fifo: parameterised synchronous FWFT FIFO with registered head, full/empty/count, and same-cycle push+pop.
- Top level holds the counter, comparator, dispatch and error logic.

Test Plan:
- Reset, write {ts=10, pl=64'hA5}, start counter at 0 -> counter_matched high only in the cycle after counter_value==10; gpo_in[63:0]=64'hA5; empty=1 afterwards.
- Write ts=5,6,7; start -> three consecutive strobes carrying ts 5,6,7 in order; late_count=0.
- Start counter, wait until counter=20, write ts=15 -> no strobe; timestamp_error pulses once; late_count=1; gpo_in unchanged.
- Fill 16 entries (counter stopped), write a 17th -> dropped; overflow_error=1; fifo_count=16. Then error_clear -> overflow_error=0.
- Two entries ts=30, ts=30 -> one strobe at 30 plus one timestamp_error; late_count=1.
- Mid-run reset with 4 queued entries -> next cycle empty=1, counter_value=0, no strobes afterwards; counter_start then verifies no stale dispatch.
